peripheral_syn_fifo: RTL

- Parametrised successor to the single-entry MMIO synchronisation register.
- Captures every qualifying MMIO commit record (instrcnt, pc, rf write data, wen) from the DUT commit stream into a DEPTH-entry FIFO.
- The co-simulation side drains the FIFO through a valid/ready handshake, so back-to-back MMIO commits are no longer overwritten.
- Adds overflow detection, a saturating drop counter, an optional non-writing-MMIO capture mode, and a last-record mirror in the legacy 128-bit syn_reg1/syn_reg2 format.

---
 rtl/peripheral_syn_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/peripheral_syn_fifo.sv
// ============================================================================
// Module      : peripheral_syn_fifo
// Description : DEPTH-entry FIFO of MMIO commit records drained by valid/ready,
//               with sticky overflow, saturating drop counter and legacy mirror.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peripheral_syn_fifo #(
  parameter int XLEN          = 64,
  parameter int CNT_W         = 64,
  parameter int DEPTH         = 8,
  parameter int CAPTURE_NOWEN = 0,
  parameter int DROP_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          dutpc,
  input  logic [XLEN-1:0]          rfData,
  input  logic [CNT_W-1:0]         instrcnt,
  input  logic                     valid,
  input  logic                     wenable,
  input  logic                     isMMIO,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [CNT_W-1:0]         out_instrcnt,
  output logic [XLEN-1:0]          out_rfdata,
  output logic                     out_wen,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_ovf,
  output logic [127:0]             syn_reg1,
  output logic [127:0]             syn_reg2
);

  localparam int   c_AW        = $clog2(DEPTH);
  localparam int   c_CW        = c_AW + 1;
  localparam logic c_NOWEN_CAP = (CAPTURE_NOWEN != 0);

  // Record storage has no reset so it can map onto distributed RAM.
  logic [XLEN-1:0]  r_mem_pc  [DEPTH];
  logic [CNT_W-1:0] r_mem_cnt [DEPTH];
  logic [XLEN-1:0]  r_mem_rf  [DEPTH];
  logic             r_mem_wen [DEPTH];

  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [127:0]      r_syn_reg1;
  logic [127:0]      r_syn_reg2;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_accept;
  logic [XLEN-1:0]   w_rf_store;
  logic [63:0]       w_cnt64;
  logic [63:0]       w_pc64;
  logic [63:0]       w_rf64;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_CW'(DEPTH));
  assign w_push     = valid & isMMIO & (wenable | c_NOWEN_CAP);
  assign w_pop      = ~w_empty & out_ready;
  // A pop on the same edge frees a slot, so a full FIFO only drops without one.
  assign w_drop     = w_push & w_full & ~w_pop;
  assign w_accept   = w_push & ~w_drop;
  assign w_rf_store = wenable ? rfData : '0;

  assign w_cnt64 = 64'(instrcnt);
  assign w_pc64  = 64'(dutpc);
  assign w_rf64  = 64'(w_rf_store);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_pc[r_wr_ptr]  <= dutpc;
      r_mem_cnt[r_wr_ptr] <= instrcnt;
      r_mem_rf[r_wr_ptr]  <= w_rf_store;
      r_mem_wen[r_wr_ptr] <= wenable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      r_syn_reg1 <= '0;
      r_syn_reg2 <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + c_AW'(1);
        r_syn_reg1 <= {w_cnt64, w_pc64};
        r_syn_reg2 <= {64'd0, w_rf64};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end

      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase

      // A drop on the clearing edge is still recorded, restarting the count at 1.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clr_ovf) begin
          r_drop_cnt <= DROP_W'(1);
        end else if (~&r_drop_cnt) begin
          r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  assign out_valid    = ~w_empty;
  assign out_pc       = out_valid ? r_mem_pc[r_rd_ptr]  : '0;
  assign out_instrcnt = out_valid ? r_mem_cnt[r_rd_ptr] : '0;
  assign out_rfdata   = out_valid ? r_mem_rf[r_rd_ptr]  : '0;
  assign out_wen      = out_valid & r_mem_wen[r_rd_ptr];
  assign count        = r_count;
  assign full         = w_full;
  assign overflow     = r_overflow;
  assign drop_cnt     = r_drop_cnt;
  assign syn_reg1     = r_syn_reg1;
  assign syn_reg2     = r_syn_reg2;

endmodule

`default_nettype wire
